// File: rtl/tt_um_seg7_counter.sv
// ---------------------------------------------------------------------------
// tt_um_seg7_counter
//   Two-digit BCD counter (00-99) shown on a time-multiplexed pair of
//   7-segment digits. The counter advances on a prescaled tick while running,
//   or once per rising edge of the step input. It can be cleared at any time.
//   Segment and digit-common polarity are chosen at run time.
//
// Parameters
//   TICK_DIV  clk cycles per automatic count while running (>= 2)
//   MUX_DIV   clk cycles each digit is shown before switching (>= 1)
//
// Ports
//   clk      in   clock, all state on rising edge
//   rst_n    in   asynchronous reset, ACTIVE-HIGH (harness name kept)
//   ena      in   tile select, ignored
//   ui_in    in   [0] run, [1] down, [2] clear, [3] step, [7:4] unused
//   uio_in   in   [7] common active level, [6] segment active level
//   uo_out   out  [6:0] segments a..g (bit0 = a), [7] decimal point
//   uio_out  out  [0] units common, [1] tens common, [7:2] = 0
//   uio_oe   out  constant 8'b0000_0011
// ---------------------------------------------------------------------------
module tt_um_seg7_counter #(
    parameter int TICK_DIV = 1000000,
    parameter int MUX_DIV  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int TW = $clog2(TICK_DIV);
    // A one-cycle mux period still needs a 1-bit counter to keep widths legal.
    localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [MW-1:0] MUX_LAST  = MW'(MUX_DIV - 1);

    // Segment pattern for one BCD digit, bit0 = segment a, 1 = lit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic          r_step_d;
    logic [TW-1:0] r_presc;
    logic [3:0]    r_units;
    logic [3:0]    r_tens;
    logic [MW-1:0] r_mux;
    logic          r_sel;      // 0 = units digit shown, 1 = tens digit shown

    logic       w_run;
    logic       w_down;
    logic       w_clear;
    logic       w_step;
    logic       w_step_rise;
    logic       w_tick;
    logic       w_event;
    logic [3:0] w_digit;
    logic [7:0] w_code;
    logic       w_unused;

    assign w_run   = r_sync2[0];
    assign w_down  = r_sync2[1];
    assign w_clear = r_sync2[2];
    assign w_step  = r_sync2[3];

    // Edge detect on the synchronized step, so a held step counts once. The
    // rise is used combinationally, so the count moves on the third clock
    // edge after the pin is first sampled high.
    assign w_step_rise = w_step & ~r_step_d;
    assign w_tick      = w_run & (r_presc == TICK_LAST);
    // Tick and step together still make only one count event.
    assign w_event     = (w_tick | w_step_rise) & ~w_clear;

    // Input synchronizer and step edge flop
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sync1  <= 4'd0;
            r_sync2  <= 4'd0;
            r_step_d <= 1'b0;
        end else begin
            r_sync1  <= ui_in[3:0];
            r_sync2  <= r_sync1;
            r_step_d <= r_sync2[3];
        end
    end

    // Prescaler: only advances while running, cleared by stop or clear
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_presc <= '0;
        end else if (w_clear || !w_run || (r_presc == TICK_LAST)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // BCD up/down counter with wrap at 99 <-> 00
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_units <= 4'd0;
            r_tens  <= 4'd0;
        end else if (w_clear) begin
            r_units <= 4'd0;
            r_tens  <= 4'd0;
        end else if (w_event) begin
            if (w_down) begin
                if (r_units == 4'd0) begin
                    r_units <= 4'd9;
                    r_tens  <= (r_tens == 4'd0) ? 4'd9 : r_tens - 4'd1;
                end else begin
                    r_units <= r_units - 4'd1;
                end
            end else begin
                if (r_units == 4'd9) begin
                    r_units <= 4'd0;
                    r_tens  <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
                end else begin
                    r_units <= r_units + 4'd1;
                end
            end
        end
    end

    // Digit multiplexer: free-running, unaffected by run or clear
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_mux <= '0;
            r_sel <= 1'b0;
        end else if (r_mux == MUX_LAST) begin
            r_mux <= '0;
            r_sel <= ~r_sel;
        end else begin
            r_mux <= r_mux + 1'b1;
        end
    end

    // Output polarity is applied combinationally so a strap change takes
    // effect immediately. The dp is logically off, so it follows polarity too.
    assign w_digit = r_sel ? r_tens : r_units;
    assign w_code  = {1'b0, seg7(w_digit)};
    assign uo_out  = uio_in[6] ? w_code : ~w_code;

    assign uio_out = {6'b0,
                      r_sel ? uio_in[7] : ~uio_in[7],
                      r_sel ? ~uio_in[7] : uio_in[7]};
    assign uio_oe  = 8'b0000_0011;

    assign w_unused = &{1'b0, ena, ui_in[7:4], uio_in[5:0]};

endmodule

// File: tb/tb_tt_um_seg7_counter.sv
module tb_tt_um_seg7_counter;

    localparam int TICK_DIV = 4;
    localparam int MUX_DIV  = 2;
    localparam logic [6:0] SEG [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'hC0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    // Reference model state: decimal count, prescale phase, edges since reset,
    // and the history of applied control nibbles (inputs act two edges late).
    int         m_cnt;
    int         m_presc;
    int         m_n;
    logic [3:0] m_hist[$];

    typedef struct {
        logic [7:0] ui;
        logic [1:0] pol;
        int         cycles;
        int         exp_cnt;
    } row_t;
    row_t tbl[16];

    tt_um_seg7_counter #(.TICK_DIV(TICK_DIV), .MUX_DIV(MUX_DIV)) dut (
        .clk(clk), .rst_n(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt = 0;
        m_presc = 0;
        m_n = 0;
        m_hist.delete();
        repeat (4) m_hist.push_back(4'h0);
    endtask

    task automatic model_edge(input logic [7:0] ui);
        logic [3:0] c;
        logic [3:0] p;
        bit tick;
        m_hist.push_back(ui[3:0]);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        c = m_hist[m_hist.size() - 3];
        p = m_hist[m_hist.size() - 4];
        m_n++;
        if (c[2]) begin
            m_cnt = 0;
            m_presc = 0;
        end else begin
            tick = c[0] && (m_presc == TICK_DIV - 1);
            m_presc = c[0] ? (m_presc + 1) % TICK_DIV : 0;
            if (tick || (c[3] && !p[3]))
                m_cnt = c[1] ? (m_cnt + 99) % 100 : (m_cnt + 1) % 100;
        end
    endtask

    function automatic bit tens_shown();
        return ((m_n / MUX_DIV) % 2) == 1;
    endfunction

    function automatic logic [7:0] exp_uo(input int cnt);
        logic [7:0] code;
        code = {1'b0, SEG[tens_shown() ? cnt / 10 : cnt % 10]};
        return uio_in[6] ? code : ~code;
    endfunction

    function automatic logic [7:0] exp_uio();
        logic c;
        c = uio_in[7];
        return tens_shown() ? {6'b0, c, ~c} : {6'b0, ~c, c};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %02h expected %02h (model count %0d)",
                     name, $time, act, exp, m_cnt);
        end
    endtask

    // Display check against an explicitly expected count.
    task automatic check_disp(input int cnt, input string name);
        #1;
        chk({name, "_seg"}, uo_out, exp_uo(cnt));
        chk({name, "_com"}, uio_out, exp_uio());
    endtask

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge(ui_in);
        @(negedge clk);
        chk("seg", uo_out, exp_uo(m_cnt));
        chk("com", uio_out, exp_uio());
        chk("oe", uio_oe, 8'h03);
    endtask

    initial begin
        logic [7:0] r;
        model_reset();
        tbl[0]  = '{8'h01, 2'b11, 42, 10};   // run up: ten ticks
        tbl[1]  = '{8'h01, 2'b11, 356, 99};
        tbl[2]  = '{8'h01, 2'b11, 4, 0};     // 99 -> 00 wrap
        tbl[3]  = '{8'h03, 2'b11, 4, 99};    // 00 -> 99 wrap down
        tbl[4]  = '{8'h00, 2'b11, 4, 99};    // stop
        tbl[5]  = '{8'h08, 2'b11, 4, 0};     // step 99 -> 00
        tbl[6]  = '{8'h00, 2'b11, 4, 0};
        tbl[7]  = '{8'h08, 2'b11, 4, 1};
        tbl[8]  = '{8'h00, 2'b11, 4, 1};
        tbl[9]  = '{8'h08, 2'b11, 4, 2};
        tbl[10] = '{8'h00, 2'b11, 4, 2};
        tbl[11] = '{8'h08, 2'b11, 12, 3};    // held step counts once
        tbl[12] = '{8'h00, 2'b11, 4, 3};
        tbl[13] = '{8'h00, 2'b00, 2, 3};
        tbl[14] = '{8'h00, 2'b01, 2, 3};
        tbl[15] = '{8'h00, 2'b11, 2, 3};

        // Reset state, outputs still driven while in reset
        @(negedge clk);
        @(negedge clk);
        chk("rst_oe", uio_oe, 8'h03);
        chk("rst_com", uio_out, 8'h01);
        chk("rst_seg", uo_out, 8'h3F);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            ui_in = tbl[i].ui;
            uio_in[7:6] = tbl[i].pol;
            for (int k = 0; k < tbl[i].cycles; k++) cyc();
            check_disp(tbl[i].exp_cnt, $sformatf("row%0d", i));
        end

        // Step latency: unchanged after two edges, counted on the third
        ui_in = 8'h08;
        cyc(); check_disp(3, "lat1");
        cyc(); check_disp(3, "lat2");
        cyc(); check_disp(4, "lat3");
        ui_in = 8'h00;
        repeat (4) cyc();

        // Clear with run: takes effect on the third edge, holds while asserted
        ui_in = 8'h05;
        cyc(); cyc(); check_disp(4, "clr_wait");
        cyc(); check_disp(0, "clr_now");
        for (int k = 0; k < 10; k++) begin
            cyc();
            check_disp(0, "clr_hold");
        end

        // Inverted polarity: units '0' reads C0, active common low
        ui_in = 8'h00;
        uio_in[7:6] = 2'b00;
        cyc();
        for (int k = 0; k < 4 && tens_shown(); k++) cyc();
        #1;
        chk("pol_c0", uo_out, 8'hC0);
        chk("pol_com", uio_out, 8'h02);
        uio_in[7:6] = 2'b11;

        // Randomized operation against the model, with one async reset
        r = 8'h01;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) r[0] = ~r[0];
            if ($urandom_range(0, 59) == 0) r[1] = ~r[1];
            r[2] = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 5) == 0) r[3] = ~r[3];
            r[7:4] = 4'($urandom);
            ui_in = r;
            if ($urandom_range(0, 99) == 0) uio_in[7:6] = 2'($urandom);
            uio_in[5:0] = 6'($urandom);
            if (k == 1500) begin
                #2 rst = 1'b1;
                model_reset();
                #1;
                chk("arst_seg", uo_out, exp_uo(0));
                chk("arst_com", uio_out, exp_uio());
                @(negedge clk);
                rst = 1'b0;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
